// File: rtl/inst_buffer.sv
// -----------------------------------------------------------------------------
// inst_buffer
//
// This is a circular instruction queue that sits between fetch/predecode and the
// backend decoder. Fetch can push up to two instructions per cycle, and the
// decoder can pop up to two per cycle. Each entry carries the instruction, its
// PC, the branch predictor sideband and the fetch-stage exception sideband, so
// the decoder sees exactly what fetch produced, in program order.
//
// Parameters
//   DEPTH          number of entries (power of two, at least 4)
//   DECODER_WIDTH  instructions per push/pop (fixed at 2)
//
// Ports
//   clk                    rising-edge clock
//   rst                    asynchronous reset, active-low
//   flush                  empties the queue on the next edge and hides the
//                          outputs in the current cycle
//   fetch_valid            per-slot push valid (slot 0 is older)
//   fetch_pc/inst          instruction PC and word per slot
//   fetch_pre_taken/addr   predictor taken flag and target per slot
//   fetch_is_exception     fetch exception flags per slot
//   fetch_exception_cause  exception causes per slot
//   pause_decoder          decoder stall; nothing is consumed this cycle
//   pause_buffer           fewer than two free entries; fetch must hold
//   pc/inst/valid/...      show-ahead view of the two oldest entries (slot 0
//                          is oldest). Data reads as zero when its valid is 0.
// -----------------------------------------------------------------------------
module inst_buffer #(
  parameter int DEPTH         = 16,
  parameter int DECODER_WIDTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [DECODER_WIDTH-1:0]             fetch_valid,
  input  logic [DECODER_WIDTH-1:0][31:0]       fetch_pc,
  input  logic [DECODER_WIDTH-1:0][31:0]       fetch_inst,
  input  logic [DECODER_WIDTH-1:0]             fetch_pre_taken,
  input  logic [DECODER_WIDTH-1:0][31:0]       fetch_pre_addr,
  input  logic [DECODER_WIDTH-1:0][1:0]        fetch_is_exception,
  input  logic [DECODER_WIDTH-1:0][1:0][6:0]   fetch_exception_cause,
  input  logic                                 pause_decoder,
  output logic                                 pause_buffer,
  output logic [DECODER_WIDTH-1:0][31:0]       pc,
  output logic [DECODER_WIDTH-1:0][31:0]       inst,
  output logic [DECODER_WIDTH-1:0]             valid,
  output logic [DECODER_WIDTH-1:0]             pre_is_branch_taken,
  output logic [DECODER_WIDTH-1:0][31:0]       pre_branch_addr,
  output logic [DECODER_WIDTH-1:0][1:0]        is_exception,
  output logic [DECODER_WIDTH-1:0][1:0][6:0]   exception_cause
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // One queue entry: 32 + 32 + 1 + 32 + 2 + 14 = 113 bits.
  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     inst;
    logic            taken;
    logic [31:0]     target;
    logic [1:0]      excp;
    logic [1:0][6:0] cause;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;

  entry_t fetch_entry [2];
  entry_t wr_data0;
  entry_t wr_data1;
  logic   push_en;
  logic   wr_en0;
  logic   wr_en1;
  logic [1:0] push_num;
  logic [1:0] pop_num;

  entry_t rd_entry [2];
  logic [DECODER_WIDTH-1:0] valid_int;

  // Pointers are exactly PTR_W bits wide and DEPTH is a power of two, so the
  // +1 wraps from DEPTH-1 to 0. A 2-wide access can therefore straddle the end
  // of the RAM and still stay in order.
  assign head_p1 = head + 1'b1;
  assign tail_p1 = tail + 1'b1;

  // Fetch must hold while fewer than two entries are free. This is derived only
  // from registered state, so it does not depend on what the decoder does in
  // the current cycle.
  assign pause_buffer = (count > CNT_W'(DEPTH - DECODER_WIDTH));

  // Put the fetch slots into entry form so the write and compaction logic can
  // handle whole entries.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      fetch_entry[k].pc     = fetch_pc[k];
      fetch_entry[k].inst   = fetch_inst[k];
      fetch_entry[k].taken  = fetch_pre_taken[k];
      fetch_entry[k].target = fetch_pre_addr[k];
      fetch_entry[k].excp   = fetch_is_exception[k];
      fetch_entry[k].cause  = fetch_exception_cause[k];
    end
  end

  // Compact the valid fetch slots onto the tail. Whichever valid slot is oldest
  // goes to tail. The second write (to tail+1) is used only when both slots are
  // valid, and it always takes slot 1. A flush or a full queue drops the push.
  assign push_en  = !pause_buffer && !flush;
  assign wr_en0   = push_en && (fetch_valid != '0);
  assign wr_en1   = push_en && (&fetch_valid);
  assign wr_data0 = fetch_valid[0] ? fetch_entry[0] : fetch_entry[1];
  assign wr_data1 = fetch_entry[1];
  assign push_num = push_en ? ({1'b0, fetch_valid[0]} + {1'b0, fetch_valid[1]}) : 2'd0;

  // The entry RAM needs no reset. Stale contents are never visible because
  // valid masks the output data.
  always_ff @(posedge clk) begin
    if (wr_en0) begin
      mem[tail] <= wr_data0;
    end
    if (wr_en1) begin
      mem[tail_p1] <= wr_data1;
    end
  end

  // Show-ahead read of the two oldest entries. valid depends on the pre-edge
  // count, so an entry pushed this cycle appears on the next cycle (there is no
  // bypass). A flush hides everything right away.
  assign valid_int[0] = (count != '0) && !flush;
  assign valid_int[1] = (count >= CNT_W'(DECODER_WIDTH)) && !flush;
  assign valid        = valid_int;

  // Drive the decoder-facing outputs. Data is forced to zero when its slot is
  // not valid, so downstream logic never sees stale RAM contents.
  always_comb begin
    rd_entry[0] = mem[head];
    rd_entry[1] = mem[head_p1];
    for (int k = 0; k < 2; k++) begin
      pc[k]                  = valid_int[k] ? rd_entry[k].pc     : 32'h0;
      inst[k]                = valid_int[k] ? rd_entry[k].inst   : 32'h0;
      pre_is_branch_taken[k] = valid_int[k] ? rd_entry[k].taken  : 1'b0;
      pre_branch_addr[k]     = valid_int[k] ? rd_entry[k].target : 32'h0;
      is_exception[k]        = valid_int[k] ? rd_entry[k].excp   : 2'b00;
      exception_cause[k]     = valid_int[k] ? rd_entry[k].cause  : 14'h0;
    end
  end

  // The decoder consumes every entry it is shown unless it stalls. valid is
  // already zero during a flush, but the explicit flush term keeps the
  // priority easy to see.
  assign pop_num = (!pause_decoder && !flush) ?
                   ({1'b0, valid_int[0]} + {1'b0, valid_int[1]}) : 2'd0;

  // Pointer and occupancy update. Reset clears the queue immediately, without a
  // clock edge. A flush beats any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_num);
      tail  <= tail + PTR_W'(push_num);
      count <= count + CNT_W'(push_num) - CNT_W'(pop_num);
    end
  end

  // The pause handshake should make overflow impossible. This check confirms
  // it in simulation.
  assert property (@(posedge clk) disable iff (!rst) count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_inst_buffer.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// tb_inst_buffer
//
// This is a directed testbench for inst_buffer. The driver records every
// accepted push in a scoreboard queue. A separate monitor checks the decoder
// side against the head of that queue on every cycle, and it pops the entries
// the decoder consumes.
// -----------------------------------------------------------------------------
module tb_inst_buffer;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] addr;
    logic [1:0]  excp;
    logic [13:0] cause;
  } ent_t;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic [1:0]            fetch_valid;
  logic [1:0][31:0]      fetch_pc;
  logic [1:0][31:0]      fetch_inst;
  logic [1:0]            fetch_pre_taken;
  logic [1:0][31:0]      fetch_pre_addr;
  logic [1:0][1:0]       fetch_is_exception;
  logic [1:0][1:0][6:0]  fetch_exception_cause;
  logic                  pause_decoder;
  logic                  pause_buffer;
  logic [1:0][31:0]      pc;
  logic [1:0][31:0]      inst;
  logic [1:0]            valid;
  logic [1:0]            pre_is_branch_taken;
  logic [1:0][31:0]      pre_branch_addr;
  logic [1:0][1:0]       is_exception;
  logic [1:0][1:0][6:0]  exception_cause;

  int   checks   = 0;
  int   failures = 0;
  ent_t sb[$];
  ent_t zero_ent = '0;

  inst_buffer #(.DEPTH(DEPTH), .DECODER_WIDTH(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush                 (flush),
    .fetch_valid           (fetch_valid),
    .fetch_pc              (fetch_pc),
    .fetch_inst            (fetch_inst),
    .fetch_pre_taken       (fetch_pre_taken),
    .fetch_pre_addr        (fetch_pre_addr),
    .fetch_is_exception    (fetch_is_exception),
    .fetch_exception_cause (fetch_exception_cause),
    .pause_decoder         (pause_decoder),
    .pause_buffer          (pause_buffer),
    .pc                    (pc),
    .inst                  (inst),
    .valid                 (valid),
    .pre_is_branch_taken   (pre_is_branch_taken),
    .pre_branch_addr       (pre_branch_addr),
    .is_exception          (is_exception),
    .exception_cause       (exception_cause)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value against its expected value and count the result.
  task automatic check_output(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Build an entry from a PC. The other fields are simple functions of the PC,
  // so each entry is distinct and its expected value is easy to work out.
  function automatic ent_t mk(input logic [31:0] p, input logic [1:0] ex,
                              input logic [13:0] c);
    ent_t e;
    e.pc    = p;
    e.inst  = {p[15:0], 16'h0013};
    e.taken = p[3];
    e.addr  = p + 32'h40;
    e.excp  = ex;
    e.cause = c;
    return e;
  endfunction

  // Run one clock cycle of fetch/decoder stimulus. Call this just after a
  // negedge. A push is recorded as accepted when the expected occupancy leaves
  // room for two entries.
  task automatic apply_stimulus(input logic [1:0] fv, input ent_t e0, input ent_t e1,
                                input logic pdec, input logic fl);
    logic accept;
    fetch_valid              = fv;
    fetch_pc[0]              = e0.pc;
    fetch_pc[1]              = e1.pc;
    fetch_inst[0]            = e0.inst;
    fetch_inst[1]            = e1.inst;
    fetch_pre_taken[0]       = e0.taken;
    fetch_pre_taken[1]       = e1.taken;
    fetch_pre_addr[0]        = e0.addr;
    fetch_pre_addr[1]        = e1.addr;
    fetch_is_exception[0]    = e0.excp;
    fetch_is_exception[1]    = e1.excp;
    fetch_exception_cause[0] = e0.cause;
    fetch_exception_cause[1] = e1.cause;
    pause_decoder            = pdec;
    flush                    = fl;
    accept = !fl && (sb.size() <= DEPTH - 2);
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else if (accept) begin
      if (fv[0]) sb.push_back(e0);
      if (fv[1]) sb.push_back(e1);
    end
    @(negedge clk);
  endtask

  // Run n cycles with no fetch pushes.
  task automatic idle(input int n, input logic pdec);
    repeat (n) apply_stimulus(2'b00, zero_ent, zero_ent, pdec, 1'b0);
  endtask

  // Monitor. It samples 2 ns after each negedge, once the driver's inputs have
  // settled. It compares the shown entries with the scoreboard head, then pops
  // the entries the decoder consumes.
  logic [1:0] exp_v;
  int         n_pop;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      exp_v[0] = (sb.size() >= 1) && !flush;
      exp_v[1] = (sb.size() >= 2) && !flush;
      check_output("valid", valid, exp_v);
      check_output("pause_buffer", pause_buffer, sb.size() > DEPTH - 2);
      for (int k = 0; k < 2; k++) begin
        if (exp_v[k]) begin
          check_output($sformatf("pc%0d", k), pc[k], sb[k].pc);
          check_output($sformatf("side%0d", k),
                       {inst[k], pre_is_branch_taken[k], pre_branch_addr[k],
                        is_exception[k], exception_cause[k]},
                       {sb[k].inst, sb[k].taken, sb[k].addr, sb[k].excp, sb[k].cause});
        end else begin
          check_output($sformatf("pc%0d_zero", k), pc[k], 32'h0);
        end
      end
      if (!pause_decoder && !flush) begin
        n_pop = int'(exp_v[0]) + int'(exp_v[1]);
        repeat (n_pop) void'(sb.pop_front());
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    rst = 1'b0;
    flush = 1'b0;
    pause_decoder = 1'b0;
    fetch_valid = '0;
    fetch_pc = '0;
    fetch_inst = '0;
    fetch_pre_taken = '0;
    fetch_pre_addr = '0;
    fetch_is_exception = '0;
    fetch_exception_cause = '0;
    repeat (2) @(negedge clk);
    check_output("reset_valid", valid, 2'b00);
    check_output("reset_pause_buffer", pause_buffer, 1'b0);
    rst = 1'b1;

    // A basic 2-wide push appears on the next cycle and is then consumed.
    $display("[TB] basic 2-wide push");
    apply_stimulus(2'b11, mk(32'h1c000000, 2'b00, 14'h0), mk(32'h1c000004, 2'b00, 14'h0), 1'b0, 1'b0);
    idle(2, 1'b0);

    // Fill to full while the decoder stalls. The held pushes must be dropped.
    $display("[TB] fill under pause_decoder");
    for (int i = 0; i < 8; i++)
      apply_stimulus(2'b11, mk(32'h1c000100 + 32'(8*i), 2'b00, 14'h0),
                     mk(32'h1c000104 + 32'(8*i), 2'b00, 14'h0), 1'b1, 1'b0);
    apply_stimulus(2'b11, mk(32'h1c0009a0, 2'b00, 14'h0), mk(32'h1c0009a4, 2'b00, 14'h0), 1'b1, 1'b0);
    apply_stimulus(2'b11, mk(32'h1c0009a8, 2'b00, 14'h0), mk(32'h1c0009ac, 2'b00, 14'h0), 1'b1, 1'b0);
    idle(9, 1'b0);

    // Single-slot pushes are compacted into consecutive entries.
    $display("[TB] compaction");
    apply_stimulus(2'b10, zero_ent, mk(32'h1c000014, 2'b00, 14'h0), 1'b1, 1'b0);
    apply_stimulus(2'b01, mk(32'h1c000018, 2'b00, 14'h0), zero_ent, 1'b1, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Single entry present, then a pop of one and a 2-wide push in the same cycle.
    $display("[TB] single entry with concurrent push");
    apply_stimulus(2'b01, mk(32'h1c000200, 2'b00, 14'h0), zero_ent, 1'b1, 1'b0);
    apply_stimulus(2'b11, mk(32'h1c000204, 2'b00, 14'h0), mk(32'h1c000208, 2'b00, 14'h0), 1'b0, 1'b0);
    idle(2, 1'b0);

    // Fill to 14, then flush while pushing and stalled.
    $display("[TB] flush");
    for (int i = 0; i < 7; i++)
      apply_stimulus(2'b11, mk(32'h1c000300 + 32'(8*i), 2'b00, 14'h0),
                     mk(32'h1c000304 + 32'(8*i), 2'b00, 14'h0), 1'b1, 1'b0);
    apply_stimulus(2'b11, mk(32'h1c0003f0, 2'b00, 14'h0), mk(32'h1c0003f4, 2'b00, 14'h0), 1'b1, 1'b1);
    idle(1, 1'b0);

    // Wrap-around with exception sideband. The pointers start odd so that
    // 2-wide accesses straddle entry 15 -> 0.
    $display("[TB] wrap-around with sideband");
    apply_stimulus(2'b01, mk(32'h1c000400, 2'b01, 14'h0008), zero_ent, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      apply_stimulus(2'b11, mk(32'h1c000404 + 32'(8*i), 2'b01, 14'h0008),
                     mk(32'h1c000408 + 32'(8*i), 2'b10, {7'h0c, 7'h00}), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      apply_stimulus(2'b11, mk(32'h1c000500 + 32'(8*i), 2'b01, 14'h0008),
                     mk(32'h1c000504 + 32'(8*i), 2'b11, {7'h02, 7'h08}), 1'b1, 1'b0);
    idle(7, 1'b0);

    // An asynchronous reset in mid-operation empties the queue without a clock edge.
    $display("[TB] async reset mid-operation");
    apply_stimulus(2'b11, mk(32'h1c000600, 2'b00, 14'h0), mk(32'h1c000604, 2'b00, 14'h0), 1'b1, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    check_output("async_reset_valid", valid, 2'b00);
    check_output("async_reset_pause_buffer", pause_buffer, 1'b0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(2'b11, mk(32'h1c000700, 2'b00, 14'h0), mk(32'h1c000704, 2'b00, 14'h0), 1'b0, 1'b0);
    idle(2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
